rf_sweep_param: RTL

//  Parametrised 2-read/1-write register file; successor to the fixed 8x16 design.

---
 rtl/rf_sweep_param.sv | 100 ++++++++++
 1 files changed

// File: rtl/rf_sweep_param.sv
// Parametrised 2-read/1-write register file with a sequential clear sweep, a ready flag and an error pulse.
// Optional build macro RF_BYPASS_EN forwards same-cycle write data to the matching read port.
module rf_sweep_param #(
  parameter int WIDTH    = 16,
  parameter int NUM_REGS = 8,
  parameter int SEL_W    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEL_W-1:0] read1regsel,
  input  logic [SEL_W-1:0] read2regsel,
  input  logic [SEL_W-1:0] writeregsel,
  input  logic [WIDTH-1:0] writedata,
  input  logic             write,
  input  logic             clear,
  output logic [WIDTH-1:0] read1data,
  output logic [WIDTH-1:0] read2data,
  output logic             ready,
  output logic             err
);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  localparam int               DEPTH = 1 << SEL_W;
  localparam logic [SEL_W:0]   NUM   = (SEL_W+1)'(NUM_REGS);
  localparam logic [SEL_W-1:0] LAST  = SEL_W'(NUM_REGS - 1);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] cnt_q, cnt_d;
  logic             err_d;
  logic             wr_in, rd1_in, rd2_in, wr_en;

  // Sized to the full select space so any select indexes safely; entries
  // at or above NUM_REGS are never written and never read out.
  logic [WIDTH-1:0] mem [DEPTH];

  assign wr_in  = {1'b0, writeregsel} < NUM;
  assign rd1_in = {1'b0, read1regsel} < NUM;
  assign rd2_in = {1'b0, read2regsel} < NUM;
  assign ready  = (state_q == IDLE);
  assign wr_en  = ready && write && wr_in;

  assign err_d = (write && !ready) || (write && !wr_in) || (ready && (!rd1_in || !rd2_in));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clear) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = IDLE;
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err     <= err_d;
    end
  end

  // A write that coincides with a clear request commits; the sweep then zeroes it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == CLEAR) mem[cnt_q] <= '0;
      else if (wr_en)       mem[writeregsel] <= writedata;
    end
  end

  always_comb begin
    read1data = '0;
    read2data = '0;
    if (ready && rd1_in) begin
      read1data = mem[read1regsel];
`ifdef RF_BYPASS_EN
      if (wr_en && (writeregsel == read1regsel)) read1data = writedata;
`endif
    end
    if (ready && rd2_in) begin
      read2data = mem[read2regsel];
`ifdef RF_BYPASS_EN
      if (wr_en && (writeregsel == read2regsel)) read2data = writedata;
`endif
    end
  end

endmodule
